// File: rtl/uart_imem_loader_if.sv
// Boot-loader bus: UART byte strobe in, imem write port and boot status out.
// slave = loader side, master = UART/CPU-subsystem side.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              load_done;
  logic              cpu_rst_n;
  logic              load_err;

  modport slave (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata, load_done, cpu_rst_n, load_err
  );

  modport master (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata, load_done, cpu_rst_n, load_err
  );
endinterface

// File: rtl/uart_imem_loader.sv
// UART-to-imem boot loader.
// Packs received bytes little-endian into 32-bit words, writes them to
// consecutive imem word slots and holds the CPU in reset until the whole
// image is stored. A partial word is dropped when the line goes idle for
// GAP_TIMEOUT cycles mid-word.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing mod-256
// checksum byte that must match before the CPU is released.
//
// state   | meaning
// COLLECT | gathering bytes of the current word
// WRITE   | one-cycle imem write of the assembled word
// CHECK   | waiting for the checksum byte (checksum build only)
// DONE    | image stored, CPU released, further bytes ignored
module uart_imem_loader #(
  parameter int IMEM_BYTES  = 256,
  parameter int ADDR_W      = 8,
  parameter int GAP_TIMEOUT = 2000000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_imem_loader_if.slave  bus
);
  localparam int WA_W  = ADDR_W - 2;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [WA_W-1:0]  LAST_WORD = WA_W'(IMEM_BYTES / 4 - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {COLLECT_S, WRITE_S, CHECK_S, DONE_S} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WA_W-1:0]   word_addr_q, word_addr_d;
  logic [23:0]       shift_q, shift_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              cpu_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_addr_d = word_addr_q;
    shift_d     = shift_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif

    // idle counter: cleared by any byte, runs only mid-word, saturates
    gap_d = gap_q;
    if (bus.rx_valid) begin
      gap_d = '0;
    end else if (byte_idx_q != 2'd0 && gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end

    unique case (state_q)
      COLLECT_S: begin
        if (bus.rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.rx_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: shift_d[7:0]   = bus.rx_data;
            2'd1: shift_d[15:8]  = bus.rx_data;
            2'd2: shift_d[23:16] = bus.rx_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = {word_addr_q, 2'b00};
              wdata_d = {bus.rx_data, shift_q};
              state_d = WRITE_S;
            end
          endcase
        end else if (byte_idx_q != 2'd0 && gap_q == GAP_LAST) begin
          byte_idx_d = 2'd0;
        end
      end
      WRITE_S: begin
        byte_idx_d = 2'd0;
        if (word_addr_q == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK_S;
`else
          state_d = DONE_S;
          done_d  = 1'b1;
`endif
        end else begin
          word_addr_d = word_addr_q + WA_W'(1);
          state_d     = COLLECT_S;
          // a byte arriving this early becomes lane 0 of the next word
          if (bus.rx_valid) begin
            shift_d[7:0] = bus.rx_data;
            byte_idx_d   = 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_d        = sum_q + bus.rx_data;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK_S: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            state_d = DONE_S;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d     = COLLECT_S;
            err_d       = 1'b1;
            word_addr_d = '0;
            sum_d       = '0;
            byte_idx_d  = 2'd0;
          end
        end
      end
`endif
      default: begin
        state_d = DONE_S;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT_S;
      byte_idx_q  <= 2'd0;
      word_addr_q <= '0;
      shift_q     <= '0;
      gap_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_addr_q <= word_addr_d;
      shift_q     <= shift_d;
      gap_q       <= gap_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      cpu_rst_n_q <= done_q;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.load_done  = done_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.load_err   = err_q;
`else
  assign bus.load_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: byte-level reference model predicting every
// imem write (cycle, address, data) and the boot status flags, checked on
// every falling edge, plus literal checks on known words.
module tb_uart_imem_loader;
  localparam int IMEM_BYTES = 256;
  localparam int ADDR_W     = 8;
  localparam int GAP        = 20;
  localparam int NWORDS     = IMEM_BYTES / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  uart_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_imem_loader #(
    .IMEM_BYTES (IMEM_BYTES),
    .ADDR_W     (ADDR_W),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] m_buf[4];
  int         m_idx, m_word, m_last;
  bit         m_done, m_check;
  logic [7:0] m_sum;
  int         done_at = -1;
  bit         err_old, err_new;
  int         err_cyc = -1;

  task automatic model_clear();
    wq.delete();
    m_idx = 0; m_word = 0; m_last = 0; m_done = 0; m_check = 0; m_sum = 8'd0;
    done_at = -1; err_old = 0; err_new = 0; err_cyc = -1;
  endtask

  // ec = clock edge count at which the DUT samples the byte
  task automatic model_byte(input logic [7:0] b, input int ec);
    if (m_done) return;
`ifdef LOADER_CHECKSUM_EN
    if (m_check) begin
      if (err_cyc >= 0) err_old = err_new;
      err_cyc = ec;
      m_check = 0;
      if (b == m_sum) begin
        err_new = 0; m_done = 1; done_at = ec;
      end else begin
        err_new = 1; m_word = 0; m_sum = 8'd0; m_idx = 0;
      end
      return;
    end
`endif
    if (m_idx != 0 && (ec - m_last - 1) >= GAP) m_idx = 0;
    m_last = ec;
    m_buf[m_idx] = b;
    m_sum += b;
    m_idx++;
    if (m_idx == 4) begin
      wq.push_back('{ec, 8'(m_word * 4), {m_buf[3], m_buf[2], m_buf[1], m_buf[0]}});
      m_idx = 0;
      if (m_word == NWORDS - 1) begin
`ifdef LOADER_CHECKSUM_EN
        m_check = 1;
`else
        m_done  = 1;
        done_at = ec + 1;
`endif
      end else begin
        m_word++;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int          wr_cnt = 0;
  logic [7:0]  last_addr;
  logic [31:0] last_data;

  always @(negedge clk) begin : cmp
    bit exp_we, exp_done, exp_cpu, exp_err;
    while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
    exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
    chk("imem_we", {31'd0, bus.imem_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk("imem_addr", {24'd0, bus.imem_addr}, {24'd0, wq[0].addr});
      chk("imem_wdata", bus.imem_wdata, wq[0].data);
      void'(wq.pop_front());
    end
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      last_addr = bus.imem_addr;
      last_data = bus.imem_wdata;
    end
    exp_done = (done_at >= 0) && (cyc >= done_at);
    exp_cpu  = (done_at >= 0) && (cyc >= done_at + 1);
    exp_err  = (err_cyc >= 0 && cyc >= err_cyc) ? err_new : err_old;
    chk("load_done", {31'd0, bus.load_done}, {31'd0, exp_done});
    chk("cpu_rst_n", {31'd0, bus.cpu_rst_n}, {31'd0, exp_cpu});
    chk("load_err", {31'd0, bus.load_err}, {31'd0, exp_err});
  end

  // ---------------- stimulus ----------------
  logic [7:0] img[IMEM_BYTES];
  logic [7:0] img_sum;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    model_byte(b, cyc + 1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // two bytes on consecutive cycles: second lands during the write cycle
  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    model_byte(b0, cyc + 1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b0;
    @(negedge clk);
    model_byte(b1, cyc + 1);
    bus.rx_data  = b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(img[i]);
  endtask

  task automatic send_cs(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b === 8'hxx) idle(1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int base;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    model_clear();
    img[0] = 8'h93; img[1] = 8'h02; img[2] = 8'hA0; img[3] = 8'h00;
    for (int i = 4; i < IMEM_BYTES; i++) img[i] = 8'((i * 37 + 11) & 8'hFF);
    img_sum = 8'd0;
    for (int i = 0; i < IMEM_BYTES; i++) img_sum += img[i];

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_load_done", {31'd0, bus.load_done}, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
    chk("rst_load_err", {31'd0, bus.load_err}, 32'd0);
    #1 rst_n = 1'b1;

    // gap timeout: exactly GAP idle cycles drops the partial word
    send_byte(8'h13); send_byte(8'h00);
    idle(GAP - 1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    chk("gap_wr_cnt", wr_cnt, 32'd1);
    chk("gap_addr", {24'd0, last_addr}, 32'h00);
    chk("gap_data", last_data, 32'h00000013);
    // one cycle short of the timeout keeps the partial word
    send_byte(8'h13); send_byte(8'h00);
    idle(GAP - 2);
    send_byte(8'h00); send_byte(8'h00);
    idle(2);
    chk("nogap_wr_cnt", wr_cnt, 32'd2);
    chk("nogap_addr", {24'd0, last_addr}, 32'h04);
    chk("nogap_data", last_data, 32'h00000013);

    // first word, then full image with a back-to-back byte pair
    do_reset();
    base = wr_cnt;
    send_range(0, 4);
    idle(2);
    chk("w0_cnt", wr_cnt - base, 32'd1);
    chk("w0_addr", {24'd0, last_addr}, 32'h00);
    chk("w0_data", last_data, 32'h00A00293);
    send_range(4, 7);
    send_pair(img[7], img[8]);
    send_range(9, IMEM_BYTES);
    send_cs(img_sum);
    idle(3);
    chk("img_wr_cnt", wr_cnt - base, 32'd64);
    chk("img_last_addr", {24'd0, last_addr}, 32'hFC);
    chk("img_done", {31'd0, bus.load_done}, 32'd1);
    chk("img_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd1);
    chk("img_err", {31'd0, bus.load_err}, 32'd0);

    // bytes after completion are ignored
    base = wr_cnt;
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA5 + i));
    idle(2);
    chk("post_wr_cnt", wr_cnt - base, 32'd0);
    chk("post_done", {31'd0, bus.load_done}, 32'd1);
    chk("post_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd1);

    // reset mid-load discards progress
    do_reset();
    base = wr_cnt;
    send_range(0, 40);
    idle(2);
    chk("part_wr_cnt", wr_cnt - base, 32'd10);
    chk("part_addr", {24'd0, last_addr}, 32'h24);
    do_reset();
    chk("rl_done_clr", {31'd0, bus.load_done}, 32'd0);
    base = wr_cnt;
    send_range(0, 4);
    idle(2);
    chk("rl_first_addr", {24'd0, last_addr}, 32'h00);
    send_range(4, IMEM_BYTES - 4);
    idle(2);
    chk("rl_63_cnt", wr_cnt - base, 32'd63);
    chk("rl_63_done", {31'd0, bus.load_done}, 32'd0);
    send_range(IMEM_BYTES - 4, IMEM_BYTES);
    send_cs(img_sum);
    idle(3);
    chk("rl_wr_cnt", wr_cnt - base, 32'd64);
    chk("rl_done", {31'd0, bus.load_done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum restarts the image, good checksum completes it
    do_reset();
    send_range(0, IMEM_BYTES);
    send_cs(img_sum ^ 8'h01);
    idle(2);
    chk("cs_bad_err", {31'd0, bus.load_err}, 32'd1);
    chk("cs_bad_done", {31'd0, bus.load_done}, 32'd0);
    base = wr_cnt;
    send_range(0, 4);
    idle(2);
    chk("cs_reload_addr", {24'd0, last_addr}, 32'h00);
    send_range(4, IMEM_BYTES);
    send_cs(img_sum);
    idle(3);
    chk("cs_good_cnt", wr_cnt - base, 32'd64);
    chk("cs_good_done", {31'd0, bus.load_done}, 32'd1);
    chk("cs_good_err", {31'd0, bus.load_err}, 32'd0);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
